// File: rtl/seq_det_scheduler.sv
// Round-robin scheduler feeding NCH parallel request words, MSB-first, into one
// serial overlapping pattern matcher; reports the served channel and its match count.
module seq_det_scheduler #(
    parameter int              NCH     = 4,
    parameter int              WORD    = 8,
    parameter int              PLEN    = 4,
    parameter logic [PLEN-1:0] PATTERN = 4'b1011,
    localparam int             CW      = (NCH > 1) ? $clog2(NCH) : 1,
    localparam int             NW      = $clog2(WORD + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NCH-1:0]      req_valid,
    input  logic [NCH*WORD-1:0] req_data,
    output logic [NCH-1:0]      req_ready,
    output logic                ser_bit,
    output logic                ser_valid,
    output logic                match_pulse,
    output logic                done_valid,
    output logic [CW-1:0]       done_ch,
    output logic [NW-1:0]       done_count,
    output logic                busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        REPORT = 2'd2
    } state_t;

    localparam logic [NCH-1:0] ONE_HOT0 = {{(NCH-1){1'b0}}, 1'b1};
    localparam logic [NW-1:0]  NW_ONE   = {{(NW-1){1'b0}}, 1'b1};

    state_t            state_r, state_s;
    logic [CW-1:0]     last_r;
    logic [CW-1:0]     gidx_s, hi_idx_s, lo_idx_s;
    logic              hi_found_s, lo_found_s, found_s;
    logic [WORD-1:0]   sh_r, word_s;
    logic [NW-1:0]     bitcnt_r, cnt_r, done_count_r;
    logic [PLEN-2:0]   hist_r;
    logic [PLEN-1:0]   hcat_s;
    logic              match_s;
    logic              ser_valid_r, match_pulse_r, done_valid_r;
    logic [CW-1:0]     done_ch_r;
    logic [NCH-1:0]    req_ready_s;

    assign hcat_s  = {hist_r, sh_r[WORD-1]};
    assign match_s = (hcat_s == PATTERN) && (bitcnt_r >= NW'(PLEN - 1));

    // Round-robin pick: channels above last_r win first, otherwise wrap to the lowest.
    always_comb begin
        hi_found_s = 1'b0;
        lo_found_s = 1'b0;
        hi_idx_s   = '0;
        lo_idx_s   = '0;
        word_s     = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            hi_idx_s   = (req_valid[i] && (CW'(i) > last_r)) ? CW'(i) : hi_idx_s;
            hi_found_s = hi_found_s | (req_valid[i] && (CW'(i) > last_r));
            lo_idx_s   = (req_valid[i] && (CW'(i) <= last_r)) ? CW'(i) : lo_idx_s;
            lo_found_s = lo_found_s | (req_valid[i] && (CW'(i) <= last_r));
        end
        found_s = hi_found_s | lo_found_s;
        gidx_s  = hi_found_s ? hi_idx_s : lo_idx_s;
        for (int c = 0; c < NCH; c++) begin
            word_s = (gidx_s == CW'(c)) ? req_data[c*WORD +: WORD] : word_s;
        end
    end

    // Next-state and combinational grant.
    always_comb begin
        state_s     = state_r;
        req_ready_s = '0;
        case (state_r)
            IDLE: begin
                if (found_s) begin
                    state_s     = SHIFT;
                    req_ready_s = ONE_HOT0 << gidx_s;
                end else begin
                    state_s = IDLE;
                end
            end
            SHIFT: begin
                if (bitcnt_r == NW'(WORD - 1)) begin
                    state_s = REPORT;
                end else begin
                    state_s = SHIFT;
                end
            end
            REPORT:  state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Datapath: capture, serialize, match counting and done reporting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_r        <= CW'(NCH - 1);
            sh_r          <= '0;
            bitcnt_r      <= '0;
            cnt_r         <= '0;
            hist_r        <= '0;
            ser_valid_r   <= 1'b0;
            match_pulse_r <= 1'b0;
            done_valid_r  <= 1'b0;
            done_ch_r     <= '0;
            done_count_r  <= '0;
        end else begin
            match_pulse_r <= 1'b0;
            done_valid_r  <= 1'b0;
            done_ch_r     <= '0;
            done_count_r  <= '0;
            case (state_r)
                IDLE: begin
                    if (found_s) begin
                        sh_r        <= word_s;
                        last_r      <= gidx_s;
                        hist_r      <= '0;
                        cnt_r       <= '0;
                        bitcnt_r    <= '0;
                        ser_valid_r <= 1'b1;
                    end else begin
                        ser_valid_r <= 1'b0;
                    end
                end
                SHIFT: begin
                    sh_r          <= sh_r << 1;
                    bitcnt_r      <= bitcnt_r + NW_ONE;
                    hist_r        <= hcat_s[PLEN-2:0];
                    cnt_r         <= cnt_r + {{(NW-1){1'b0}}, match_s};
                    match_pulse_r <= match_s;
                    if (bitcnt_r == NW'(WORD - 1)) begin
                        ser_valid_r  <= 1'b0;
                        done_valid_r <= 1'b1;
                        done_ch_r    <= last_r;
                        done_count_r <= cnt_r + {{(NW-1){1'b0}}, match_s};
                    end else begin
                        ser_valid_r <= 1'b1;
                    end
                end
                REPORT: begin
                    ser_valid_r <= 1'b0;
                end
                default: begin
                    ser_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready   = req_ready_s;
    assign ser_bit     = sh_r[WORD-1] & ser_valid_r;
    assign ser_valid   = ser_valid_r;
    assign match_pulse = match_pulse_r;
    assign done_valid  = done_valid_r;
    assign done_ch     = done_ch_r;
    assign done_count  = done_count_r;
    assign busy        = (state_r != IDLE);

endmodule

// File: doc/seq_det_scheduler.md
Name: seq_det_scheduler

Overview:
- Round-robin scheduler that shares one serial pattern-match engine between NCH requesters.
- Each requester offers a WORD-bit word through a valid/ready handshake.
- The scheduler grants one channel, serializes its word MSB-first through an internal programmable matcher, and reports the channel and match count.
- Sits between the parallel requester ports and the serial detection path.

Parameters:
- NCH, 4: number of requesting channels (2..8).
- WORD, 8: bits per request word (>= PLEN).
- PLEN, 4: pattern length in bits (2..WORD).
- PATTERN, 4'b1011: pattern to detect. The first serialized bit is compared against PATTERN[PLEN-1].

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NCH  per-channel word valid.
- req_data  in  NCH*WORD  channel c word at bits [c*WORD +: WORD].
- req_ready  out  NCH  one-hot grant/accept. Transfer occurs when req_valid[c] & req_ready[c].
- ser_bit  out  1  serialized bit currently presented to the matcher.
- ser_valid  out  1  ser_bit is valid this cycle.
- match_pulse  out  1  one-cycle pulse, high the cycle after a pattern-completing bit.
- done_valid  out  1  one-cycle completion strobe.
- done_ch  out  max(1,clog2(NCH))  channel reported by done.
- done_count  out  clog2(WORD+1)  number of matches in the reported word.
- busy  out  1  high whenever the FSM is not IDLE.

Behaviour:
- Reset (asynchronous, rst=1):
  - FSM goes to IDLE; last_grant=NCH-1, so ch0 has first priority.
  - Shift register, bit counter, history and match count are cleared.
  - All outputs are 0.
- FSM states: IDLE, SHIFT, REPORT.
- IDLE:
  - If any req_valid is high, select g = first asserted channel searching from (last_grant+1) mod NCH upward with wrap.
  - req_ready[g]=1 combinationally in that cycle; all other ready bits are 0.
  - On the clock edge: capture req_data[g], set last_grant=g, clear history and count, bitcnt=0, go to SHIFT.
  - With no valid request, stay in IDLE with req_ready=0.
- SHIFT (exactly WORD cycles):
  - ser_valid=1; ser_bit = shift register MSB.
  - Each edge: shift left, bitcnt++, history = {history[PLEN-2:0], ser_bit}.
  - Match condition: {history[PLEN-2:0], ser_bit} == PATTERN and bitcnt >= PLEN-1.
  - On a match, count++ and match_pulse is registered high for the next cycle.
  - Detection is overlapping.
  - After the bit with bitcnt==WORD-1, go to REPORT.
- REPORT (1 cycle):
  - done_valid=1, done_ch=last_grant, done_count=final count (includes a match on the last bit).
  - match_pulse from the last bit appears in this same cycle.
  - Next state is IDLE.
- Latency and throughput:
  - Accept edge E0; bits on cycles E0+1..E0+WORD; done in cycle E0+WORD+1.
  - Next accept can happen at the end of cycle E0+WORD+2.
  - One word per WORD+2 cycles.
- Outside SHIFT: ser_valid=0 and ser_bit=0. Outside REPORT: done_* = 0.
- Boundaries:
  - No match spans two words; history is cleared at each accept.
  - A requester that drops req_valid during SHIFT has no effect; its word is already captured.
  - A requester that keeps req_valid high is re-granted only after all other pending channels are served.
  - A single requester alone is granted back-to-back.
  - Maximum done_count is WORD-PLEN+1 (all-ones pattern on an all-ones word); the counter must not wrap.
  - rst asserted mid-SHIFT or mid-REPORT aborts the operation: no done_valid is issued and last_grant returns to NCH-1.
  - req_data changing while not granted is ignored.

Test Plan:
- Reset, then ch1 only, word 8'b1011_1011 -> req_ready=4'b0010 for one cycle; ser_bit stream 1,0,1,1,1,0,1,1; match_pulse in cycles 5 and 9 after accept; done_ch=1, done_count=2.
- Overlap: ch0 word 8'b1011_0110 -> done_count=2 (matches ending at bits 4 and 7).
- Round-robin: all four valid and held high -> grant order 0,1,2,3,0; accepts spaced exactly 10 cycles apart.
- No cross-word match: ch2 sends 8'b0000_0101, then 8'b1000_0000 -> both words report done_count=0.
- Reset mid-SHIFT: assert rst at bit 3 of a ch3 word -> outputs go 0 immediately, no done_valid; next request from ch3 and ch0 grants ch0 first.
- Saturation: PATTERN=4'b1111, word 8'hFF -> done_count=5; five match_pulses on consecutive cycles.
